md_sched: RTL

- Multiply/divide scheduler for the 5-stage pipeline.
- Accepts MD operations issued from the E stage and computes the results internally.
- Holds the HI/LO registers and sequences multi-cycle mult/div latency with a busy counter.
- Raises a stall request toward the D stage while an MD-dependent instruction would otherwise race an in-flight operation.

---
 rtl/md_sched_if.sv | 22 ++
 rtl/md_sched.sv | 96 +++++++++
 2 files changed

// File: rtl/md_sched_if.sv
// E-stage issue bus and HI/LO/stall return bus of the multiply/divide scheduler.
interface md_sched_if;
    logic        E_start;
    logic [2:0]  E_MDOp;
    logic [31:0] E_A;
    logic [31:0] E_B;
    logic        D_isMD;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        MDStall;

    modport master (
        output E_start, E_MDOp, E_A, E_B, D_isMD,
        input  HI, LO, busy, MDStall
    );

    modport slave (
        input  E_start, E_MDOp, E_A, E_B, D_isMD,
        output HI, LO, busy, MDStall
    );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide scheduler: computes the result at issue, parks it in pHI/pLO,
// and exposes it on HI/LO only after the architectural latency has elapsed.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    md_sched_if.slave   bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi, r_lo, r_phi, r_plo;

    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic               w_neg_a, w_neg_b;
    logic [31:0]        w_abs_a, w_abs_b, w_q0, w_r0, w_q, w_r;

    assign w_prod_s = $signed({{32{bus.E_A[31]}}, bus.E_A}) * $signed({{32{bus.E_B[31]}}, bus.E_B});
    assign w_prod_u = {32'd0, bus.E_A} * {32'd0, bus.E_B};

    // Signed divide runs on magnitudes; 0x80000000/-1 wraps back to 0x80000000 naturally.
    always_comb begin
        w_neg_a = (bus.E_MDOp == 3'd2) & bus.E_A[31];
        w_neg_b = (bus.E_MDOp == 3'd2) & bus.E_B[31];
        w_abs_a = w_neg_a ? (32'd0 - bus.E_A) : bus.E_A;
        w_abs_b = w_neg_b ? (32'd0 - bus.E_B) : bus.E_B;
        w_q0    = 32'd0;
        w_r0    = 32'd0;
        w_q     = 32'hFFFF_FFFF;
        w_r     = bus.E_A;
        if (bus.E_B != 32'd0) begin
            w_q0 = w_abs_a / w_abs_b;
            w_r0 = w_abs_a % w_abs_b;
            w_q  = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q0) : w_q0;
            w_r  = w_neg_a ? (32'd0 - w_r0) : w_r0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.E_start) begin
                        case (bus.E_MDOp)
                            3'd0: begin
                                {r_phi, r_plo} <= w_prod_s;
                                r_cnt          <= 4'(MULT_CYCLES);
                                r_state        <= S_RUN;
                            end
                            3'd1: begin
                                {r_phi, r_plo} <= w_prod_u;
                                r_cnt          <= 4'(MULT_CYCLES);
                                r_state        <= S_RUN;
                            end
                            3'd2, 3'd3: begin
                                r_phi   <= w_r;
                                r_plo   <= w_q;
                                r_cnt   <= 4'(DIV_CYCLES);
                                r_state <= S_RUN;
                            end
                            3'd4:    r_hi <= bus.E_A;
                            3'd5:    r_lo <= bus.E_A;
                            default: ;
                        endcase
                    end
                end
                default: begin
                    // Issues arriving while running are dropped; the pipeline should have stalled them.
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_hi    <= r_phi;
                        r_lo    <= r_plo;
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.HI      = r_hi;
    assign bus.LO      = r_lo;
    assign bus.busy    = (r_state == S_RUN);
    assign bus.MDStall = bus.D_isMD & ((r_state == S_RUN) | bus.E_start);
endmodule
